// File: rtl/nn_mul_pkg.sv
// Shared types and helpers for the pipelined NN multiplier.
// Stage data is carried at a fixed P_W_MAX width. Each product is sign- or
// zero-extended into that width, so the shift and range checks do not depend
// on the operand widths. din0_WIDTH + din1_WIDTH must not exceed P_W_MAX.
package nn_mul_pkg;

    localparam int DIN0_W_DEF = 23;
    localparam int DIN1_W_DEF = 23;
    localparam int P_W        = DIN0_W_DEF + DIN1_W_DEF;
    localparam int DOUT_W_DEF = P_W - 1;
    localparam int P_W_MAX    = 64;

    typedef struct packed {
        logic               valid;
        logic               sgn;
        logic [P_W_MAX-1:0] data;
    } stage_t;

    // 1 when r (already extended per mode) is representable in width bits.
    function automatic logic fits(input logic [P_W_MAX-1:0] r,
                                  input logic signed_mode,
                                  input int width);
        logic [P_W_MAX-1:0] hi;
        if (signed_mode) begin
            hi = $signed(r) >>> (width - 1);
            return (hi == '0) || (hi == '1);
        end else begin
            hi = r >> width;
            return hi == '0;
        end
    endfunction

    // Returns r unchanged when it fits; otherwise returns the extreme of the
    // mode's range on the side of r's sign.
    function automatic logic [P_W_MAX-1:0] sat_clip(input logic [P_W_MAX-1:0] r,
                                                    input logic signed_mode,
                                                    input int width);
        logic [P_W_MAX-1:0] ones;
        ones = '1;
        if (fits(r, signed_mode, width)) begin
            return r;
        end else if (signed_mode) begin
            return r[P_W_MAX-1] ? (ones << (width - 1)) : ~(ones << (width - 1));
        end else begin
            return ~(ones << width);
        end
    endfunction

endpackage

// File: rtl/nn_mul_post.sv
// Final-stage post-processing: right shift of the product, range check, and
// either wrap (default build) or clamp to the mode's extreme (NN_MUL_SAT_EN).
module nn_mul_post
    import nn_mul_pkg::*;
#(
    parameter int dout_WIDTH = DOUT_W_DEF,
    parameter int SHIFT      = 0
) (
    input  logic                  sgn,
    input  logic [P_W_MAX-1:0]    data,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    logic [P_W_MAX-1:0] r_val;

    // Shift (arithmetic for signed beats), then check range and select the result.
    always_comb begin
        if (sgn) begin
            r_val = $signed(data) >>> SHIFT;
        end else begin
            r_val = data >> SHIFT;
        end
        ovf = !fits(r_val, sgn, dout_WIDTH);
`ifdef NN_MUL_SAT_EN
        dout = dout_WIDTH'(sat_clip(r_val, sgn, dout_WIDTH));
`else
        dout = r_val[dout_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/nn_mul_pipe.sv
// Pipelined signed/unsigned integer multiplier with valid/ready flow control.
// Stage 1 forms the exact product. The last stage applies the shift, the
// overflow check and the optional clamp (NN_MUL_SAT_EN). Every stage advances
// only on en = !out_valid || out_ready, so a stall freezes the whole pipe.
module nn_mul_pipe
    import nn_mul_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W_DEF,
    parameter int din1_WIDTH = DIN1_W_DEF,
    parameter int dout_WIDTH = DOUT_W_DEF,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_signed,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int PROD_W = din0_WIDTH + din1_WIDTH;

    logic                  en;
    logic [PROD_W-1:0]     a_ext;
    logic [PROD_W-1:0]     b_ext;
    logic [PROD_W-1:0]     prod;
    stage_t                stage_in;
    stage_t                post_in;
    logic                  mid_busy;
    logic [dout_WIDTH-1:0] post_dout;
    logic                  post_ovf;
    logic                  out_valid_reg;
    logic                  ovf_reg;
    logic [dout_WIDTH-1:0] dout_reg;

    // Enable, operand extension and the stage-1 multiply.
    always_comb begin
        en = !out_valid_reg || out_ready;
        if (in_signed) begin
            a_ext = PROD_W'($signed(din0));
            b_ext = PROD_W'($signed(din1));
        end else begin
            a_ext = PROD_W'(din0);
            b_ext = PROD_W'(din1);
        end
        prod           = a_ext * b_ext;
        stage_in.valid = in_valid;
        stage_in.sgn   = in_signed;
        if (in_signed) begin
            stage_in.data = P_W_MAX'($signed(prod));
        end else begin
            stage_in.data = P_W_MAX'(prod);
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign post_in  = stage_in;
            assign mid_busy = 1'b0;
        end else begin : g_multi
            stage_t stage_reg [1:NUM_STAGE-1];

            for (genvar gi = 1; gi < NUM_STAGE; gi++) begin : g_stage
                stage_t stage_prev;

                if (gi == 1) begin : g_first
                    assign stage_prev = stage_in;
                end else begin : g_rest
                    assign stage_prev = stage_reg[gi-1];
                end

                // Stage register. Reset drops the valid bit; data is held on a stall.
                always_ff @(posedge ap_clk) begin
                    if (!ap_rst_n) begin
                        stage_reg[gi].valid <= 1'b0;
                    end else if (en) begin
                        stage_reg[gi] <= stage_prev;
                    end
                end
            end

            // An intermediate stage is occupied when any of its valid bits is set.
            always_comb begin
                mid_busy = 1'b0;
                for (int i = 1; i < NUM_STAGE; i++) begin
                    mid_busy = mid_busy | stage_reg[i].valid;
                end
            end

            assign post_in = stage_reg[NUM_STAGE-1];
        end
    endgenerate

    nn_mul_post #(
        .dout_WIDTH (dout_WIDTH),
        .SHIFT      (SHIFT)
    ) u_post (
        .sgn  (post_in.sgn),
        .data (post_in.data),
        .dout (post_dout),
        .ovf  (post_ovf)
    );

    // Output stage. ovf is forced low on bubbles so it never flags a stale value.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            dout_reg      <= '0;
        end else if (en) begin
            out_valid_reg <= post_in.valid;
            ovf_reg       <= post_in.valid & post_ovf;
            dout_reg      <= post_dout;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_reg;
    assign ovf       = ovf_reg;
    assign dout      = dout_reg;
    assign busy      = mid_busy | out_valid_reg;

endmodule
